// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the CPU and the loader/debug port.
// Round-robin on ties, registered request fields, MEM_LAT-cycle accesses, one-cycle ack.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

    state_e            state_q, state_d;
    logic [3:0]        lat_q, lat_d;
    logic              last_q, last_d;     // 1 = loader was served last
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

    logic in_access;
    logic last_cycle;
    logic grant_ldr;

    assign in_access  = (state_q == StAccess);
    assign last_cycle = (lat_q == 4'(MEM_LAT - 1));
    // Loader wins when alone, or on a tie when the CPU was served last.
    assign grant_ldr  = ldr_req && (!cpu_req || !last_q);

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        last_d      = last_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        case (state_q)
            StIdle: begin
                if (cpu_req || ldr_req) begin
                    owner_d = grant_ldr;
                    we_d    = grant_ldr ? ldr_we    : cpu_we;
                    addr_d  = grant_ldr ? ldr_addr  : cpu_addr;
                    wdata_d = grant_ldr ? ldr_wdata : cpu_wdata;
                    lat_d   = 4'd0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                lat_d = lat_q + 4'd1;
                if (last_cycle) begin
                    if (!we_q) begin
                        if (owner_q) ldr_rdata_d = mem_rdata;
                        else         cpu_rdata_d = mem_rdata;
                    end
                    last_d  = owner_q;
                    state_d = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            lat_q       <= 4'd0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    // Write strobe only in the final access cycle: one write per transaction.
    always_comb begin
        busy      = (state_q != StIdle);
        mem_addr  = in_access ? addr_q  : '0;
        mem_wdata = in_access ? wdata_q : '0;
        mem_read  = in_access && !we_q;
        mem_write = in_access && we_q && last_cycle;
        cpu_ack   = (state_q == StAck) && !owner_q;
        ldr_ack   = (state_q == StAck) && owner_q;
        owner     = owner_q;
        cpu_rdata = cpu_rdata_q;
        ldr_rdata = ldr_rdata_q;
    end

endmodule
